// File: rtl/mod_updown_counter_if.sv
// Bundles the control inputs and status outputs of mod_updown_counter.
// The slave modport is for the counter; the master modport is for whatever drives it.
interface mod_updown_counter_if #(
  parameter int unsigned N = 24
);
  logic         en;
  logic         syn_clr;
  logic         load;
  logic [N-1:0] d;
  logic         up;
  logic [N-1:0] limit;
  logic         oneshot;
  logic         start;
  logic [N-1:0] q;
  logic         max_tick;
  logic         min_tick;
  logic         wrap_tick;
  logic         done;

  modport slave (
    input  en, syn_clr, load, d, up, limit, oneshot, start,
    output q, max_tick, min_tick, wrap_tick, done
  );

  modport master (
    output en, syn_clr, load, d, up, limit, oneshot, start,
    input  q, max_tick, min_tick, wrap_tick, done
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulus up/down counter over 0..limit with clear, load, free-run and one-shot modes.
// The one-shot FSM runs once from the start value to the terminal value, then parks in DONE.
module mod_updown_counter #(
  parameter int unsigned N           = 24,
  parameter int unsigned ONESHOT_DEF = 0
) (
  input logic                   clk,
  input logic                   reset,
  mod_updown_counter_if.slave   bus
);

  if (N < 2) begin : gen_bad_width
    $error("mod_updown_counter: N must be at least 2");
  end
  if (ONESHOT_DEF > 1) begin : gen_bad_mode
    $error("mod_updown_counter: ONESHOT_DEF must be 0 or 1");
  end

  localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         done_q, done_d;

  logic [N-1:0] step_val;
  logic         step_wrap;
  logic [N-1:0] start_val;
  logic [N-1:0] term_val;

  // One enabled step in the current direction, including the wrap cases.
  always_comb begin
    step_val  = q_q;
    step_wrap = 1'b0;
    if (bus.up) begin
      if (q_q >= bus.limit) begin
        step_val  = '0;
        step_wrap = 1'b1;
      end else begin
        step_val  = q_q + One;
      end
    end else if (q_q == '0) begin
      step_val  = bus.limit;
      step_wrap = 1'b1;
    end else if (q_q > bus.limit) begin
      // Out-of-range value (from load) snaps back to the top without a wrap.
      step_val  = bus.limit;
    end else begin
      step_val  = q_q - One;
    end
  end

  assign start_val = bus.up ? '0 : bus.limit;
  assign term_val  = bus.up ? bus.limit : '0;

  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    wrap_d  = 1'b0;

    if (bus.syn_clr) begin
      q_d     = '0;
      state_d = StIdle;
    end else if (bus.load) begin
      q_d     = bus.d;
      state_d = bus.oneshot ? state_q : StIdle;
    end else if (!bus.oneshot) begin
      state_d = StIdle;
      if (bus.en) begin
        q_d    = step_val;
        wrap_d = step_wrap;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            q_d     = start_val;
            state_d = StRun;
          end
        end
        StRun: begin
          if (bus.start) begin
            q_d = start_val;
          end else if (bus.en) begin
            // Reaching (or overshooting) the terminal value parks instead of wrapping.
            if (step_wrap || (step_val == term_val)) begin
              q_d     = term_val;
              state_d = StDone;
            end else begin
              q_d = step_val;
            end
          end
        end
        StDone: begin
          if (bus.start) begin
            q_d     = start_val;
            state_d = StRun;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q     <= '0;
      state_q <= StIdle;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.wrap_tick = wrap_q;
  assign bus.done      = done_q;
  assign bus.max_tick  = (q_q == bus.limit);
  assign bus.min_tick  = (q_q == '0);

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The block SHALL have parameter N, default 24, giving the counter width in bits (N >= 2).
REQ-002 The block SHALL have parameter ONESHOT_DEF, default 0, giving the mode selected while mode is not being driven (used only for the bench tie-off).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  count enable.
REQ-006 Port syn_clr  input  1  synchronous clear.
REQ-007 Port load  input  1  synchronous parallel load of d.
REQ-008 Port d  input  N  load value.
REQ-009 Port up  input  1  direction: 1 = up, 0 = down.
REQ-010 Port limit  input  N  modulus terminal value; the count range is 0..limit.
REQ-011 Port oneshot  input  1  mode: 0 = free-run, 1 = one-shot.
REQ-012 Port start  input  1  one-shot trigger.
REQ-013 Port q  output  N  current count, registered.
REQ-014 Port max_tick  output  1  combinational; high when q == limit.
REQ-015 Port min_tick  output  1  combinational; high when q == 0.
REQ-016 Port wrap_tick  output  1  registered one-cycle pulse after a wrap.
REQ-017 Port done  output  1  registered; high while the one-shot FSM is in DONE.

Function
REQ-018 Per-cycle priority SHALL be: syn_clr > load > start (one-shot only) > count step.
REQ-019 syn_clr SHALL:
- set q = 0;
- force the FSM to IDLE;
- clear wrap_tick on the next edge.
REQ-020 load SHALL set q = d, with the FSM state unchanged; d > limit is accepted as-is.
REQ-021 Up count step (en=1, up=1):
- q < limit: q+1;
- q >= limit: q = 0, and wrap_tick = 1 on the next cycle.
REQ-022 Down count step (en=1, up=0):
- q == 0: q = limit, and wrap_tick = 1 on the next cycle;
- q > limit: q = limit, with no wrap_tick;
- otherwise: q-1.
REQ-023 With en=0, q SHALL hold and wrap_tick SHALL be 0 on the next cycle.
REQ-024 limit = 0 SHALL hold q at 0; every enabled step wraps and pulses wrap_tick.
REQ-025 All arithmetic SHALL be N-bit unsigned with no overflow beyond limit; limit = 2^N-1 gives full binary wrap.
REQ-026 Free-run mode (oneshot=0): count steps per REQ-021/022 every enabled cycle, the FSM is held in IDLE, and done = 0.
REQ-027 One-shot FSM states SHALL be IDLE, RUN and DONE.
REQ-028 IDLE: q holds.
- start=1 -> RUN;
- q is loaded with 0 if up=1, or with limit if up=0.
REQ-029 RUN: enabled steps per REQ-021/022, except that the step reaching the terminal value moves to DONE instead of wrapping.
- Terminal value: limit if up=1, 0 if up=0.
- No wrap_tick is issued on that step.
REQ-030 RUN: start=1 SHALL restart, reloading the start value per REQ-028 and staying in RUN.
REQ-031 DONE: done = 1 and q holds at the terminal value; start=1 -> RUN with reload per REQ-028.
REQ-032 Deasserting oneshot in any state SHALL move the FSM to IDLE on the next edge, with q unchanged; free-run counting resumes that same edge.
REQ-033 Changing up or limit mid-RUN SHALL take effect on the next step; no state is lost.

Reset
REQ-034 Asynchronous reset SHALL immediately set:
- q = 0;
- FSM = IDLE;
- wrap_tick = 0;
- done = 0.
REQ-035 Reset mid-operation SHALL abort any run; after release, the first count or start is acted on at the first rising edge.
REQ-036 With q = 0 held in reset: max_tick = 1 if limit = 0, else 0; min_tick = 1.

Verification
REQ-037 Free-run up: N=4, limit=9, en=1, up=1 from reset.
- Expected q: 0..9, 0.
- max_tick high at q=9; wrap_tick high the cycle q returns to 0; the period is 10 cycles.
REQ-038 Free-run down with out-of-range load: limit=5, load d=12, then en=1, up=0.
- Expected q: 12, 5, 4, 3, 2, 1, 0, 5.
- Exactly one wrap_tick, the cycle after 0 -> 5.
REQ-039 One-shot up: oneshot=1, limit=3, start pulse.
- Expected q: 0, 1, 2, 3, after which done = 1 and q holds at 3 with no wrap_tick.
- A second start returns to q = 0 and RUN.
REQ-040 Priority collision: syn_clr=1, load=1, d=7, en=1, all in the same cycle.
- Expected: q = 0 and FSM = IDLE.
- Next cycle with load only: q = 7.
REQ-041 Reset mid-run: one-shot RUN at q=2, assert reset between edges.
- Expected: q, wrap_tick and done = 0 immediately, without waiting for a clock edge.
- After release with oneshot=1 and no start, q holds at 0.
REQ-042 Full-width wrap: N=24, limit=2^24-1, load d=2^24-2, en=1, up=1.
- Expected q: 2^24-2, 2^24-1 (max_tick=1), 0, with wrap_tick pulsed once.
